// File: rtl/cam_reg_init.sv
// cam_reg_init: power-up delay, then one I2C register write per ROM entry into i2c_m_if; optional readback via CAM_INIT_READBACK_EN.
// Latency: first wr at PWRUP_MS*CLK_HZ/1000 + 3 cycles after reset release; FETCH is one registered ROM cycle.
// Backpressure: each command waits for busy low, pulses once, then tracks busy high and low; busy never rising times out.
module cam_reg_init #(
    parameter logic [6:0] DEV_ADR  = 7'h21,
    parameter int          CLK_HZ   = 40000000,
    parameter int          PWRUP_MS = 10,
    parameter int          BUSY_TO  = 16
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        start,
    output logic        wr,
    output logic        rd,
    output logic [6:0]  adr,
    output logic [31:0] wr_data,
    output logic [2:0]  wr_bytes,
    output logic [2:0]  rd_bytes,
    input  logic [31:0] rd_data,
    input  logic        rd_data_en,
    input  logic        busy,
    output logic        init_busy,
    output logic        init_done,
    output logic        err,
    output logic [5:0]  err_idx
);
    localparam int          MS_CYC   = (CLK_HZ >= 1000) ? CLK_HZ / 1000 : 1;
    localparam logic [31:0] MS_LAST  = 32'(MS_CYC - 1);
    localparam logic [15:0] TMO_LAST = 16'(BUSY_TO - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWRUP,
        S_FETCH,
        S_DLY,
        S_ISSUE,
        S_WAIT_H,
        S_WAIT_L,
`ifdef CAM_INIT_READBACK_EN
        S_RB_A,
        S_RB_R,
        S_RB_C,
`endif
        S_DONE
    } state_t;

    function automatic logic [15:0] rom_entry(input logic [5:0] i);
        case (i)
            6'd0:    rom_entry = 16'h1280;
            6'd1:    rom_entry = 16'hFE0A;
            6'd2:    rom_entry = 16'h1204;
            6'd3:    rom_entry = 16'h40D0;
            6'd4:    rom_entry = 16'h1101;
            6'd5:    rom_entry = 16'h0C04;
            6'd6:    rom_entry = 16'h3E19;
            6'd7:    rom_entry = 16'h7211;
            6'd8:    rom_entry = 16'h73F1;
            default: rom_entry = 16'hFFFF;
        endcase
    endfunction

    state_t      state_q;
    logic [5:0]  idx_q;
    logic [15:0] ent_q;
    logic [31:0] ms_cnt_q;
    logic [15:0] ms_left_q;
    logic [15:0] tmo_q;
    logic        wr_q;
    logic [31:0] wr_data_q;
    logic [2:0]  wr_bytes_q;
    logic        init_busy_q;
    logic        init_done_q;
    logic        err_q;
    logic [5:0]  err_idx_q;

    logic [5:0]  idx_d;
    logic [15:0] ent_d;
    logic [7:0]  ent_reg;
    logic [7:0]  ent_val;
    logic        ms_tick;
    logic        tmr_done;

    // The ROM word for the next index is registered alongside the index itself.
    assign idx_d    = idx_q + 6'd1;
    assign ent_d    = rom_entry(idx_d);
    assign ent_reg  = ent_q[15:8];
    assign ent_val  = ent_q[7:0];
    assign ms_tick  = (ms_cnt_q == MS_LAST);
    assign tmr_done = (ms_left_q == 16'd0) || (ms_tick && (ms_left_q == 16'd1));

`ifdef CAM_INIT_READBACK_EN
    logic        rd_q;
    logic [2:0]  rd_bytes_q;
    logic [1:0]  ph_q;
    logic [7:0]  rb_q;
    logic        rb_vld_q;
    logic        unused_rb;
    assign rd        = rd_q;
    assign rd_bytes  = rd_bytes_q;
    assign unused_rb = ^rd_data[23:0];
`else
    logic        unused_rb;
    assign rd        = 1'b0;
    assign rd_bytes  = 3'd0;
    assign unused_rb = ^{rd_data, rd_data_en};
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            ent_q       <= '0;
            ms_cnt_q    <= '0;
            ms_left_q   <= '0;
            tmo_q       <= '0;
            wr_q        <= 1'b0;
            wr_data_q   <= '0;
            wr_bytes_q  <= '0;
            init_busy_q <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            err_idx_q   <= '0;
`ifdef CAM_INIT_READBACK_EN
            rd_q        <= 1'b0;
            rd_bytes_q  <= '0;
            ph_q        <= '0;
            rb_q        <= '0;
            rb_vld_q    <= 1'b0;
`endif
        end else begin
            wr_q <= 1'b0;
`ifdef CAM_INIT_READBACK_EN
            rd_q <= 1'b0;
            if (rd_data_en) begin
                rb_q     <= rd_data[31:24];
                rb_vld_q <= 1'b1;
            end
`endif
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (state_q == S_IDLE || start) begin
                        state_q     <= S_PWRUP;
                        idx_q       <= '0;
                        ent_q       <= rom_entry(6'd0);
                        ms_cnt_q    <= '0;
                        ms_left_q   <= 16'(PWRUP_MS);
                        init_busy_q <= 1'b1;
                        init_done_q <= 1'b0;
                        err_q       <= 1'b0;
                        err_idx_q   <= '0;
                    end
                end
                S_PWRUP, S_DLY: begin
                    if (tmr_done) begin
                        state_q <= S_FETCH;
                        if (state_q == S_DLY) begin
                            idx_q <= idx_d;
                            ent_q <= ent_d;
                        end
                    end else begin
                        ms_cnt_q <= ms_tick ? '0 : ms_cnt_q + 32'd1;
                        if (ms_tick) begin
                            ms_left_q <= ms_left_q - 16'd1;
                        end
                    end
                end
                S_FETCH: begin
                    // Entry 63 terminates the walk even without an END marker.
                    if (ent_reg == 8'hFF || idx_q == 6'd63) begin
                        state_q     <= S_DONE;
                        init_busy_q <= 1'b0;
                        init_done_q <= 1'b1;
                    end else if (ent_reg == 8'hFE) begin
                        state_q   <= S_DLY;
                        ms_cnt_q  <= '0;
                        ms_left_q <= {8'h00, ent_val};
                    end else begin
                        state_q    <= S_ISSUE;
                        wr_data_q  <= {ent_q, 16'h0000};
                        wr_bytes_q <= 3'd2;
`ifdef CAM_INIT_READBACK_EN
                        ph_q       <= 2'd0;
`endif
                    end
                end
                S_ISSUE: begin
                    if (!busy) begin
                        wr_q    <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= S_WAIT_H;
                    end
                end
                S_WAIT_H: begin
                    if (busy) begin
                        state_q <= S_WAIT_L;
                    end else if (tmo_q == TMO_LAST) begin
                        if (!err_q) begin
                            err_idx_q <= idx_q;
                        end
                        err_q   <= 1'b1;
                        state_q <= S_WAIT_L;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                S_WAIT_L: begin
                    if (!busy) begin
`ifdef CAM_INIT_READBACK_EN
                        case (ph_q)
                            2'd0: begin
                                // Soft-reset/COM7 register is write-only in practice; skip its readback.
                                if (ent_reg == 8'h12) begin
                                    state_q <= S_FETCH;
                                    idx_q   <= idx_d;
                                    ent_q   <= ent_d;
                                end else begin
                                    state_q    <= S_RB_A;
                                    wr_bytes_q <= 3'd1;
                                end
                            end
                            2'd1: begin
                                state_q    <= S_RB_R;
                                rd_bytes_q <= 3'd1;
                            end
                            default: state_q <= S_RB_C;
                        endcase
`else
                        state_q <= S_FETCH;
                        idx_q   <= idx_d;
                        ent_q   <= ent_d;
`endif
                    end
                end
`ifdef CAM_INIT_READBACK_EN
                S_RB_A: begin
                    if (!busy) begin
                        wr_q    <= 1'b1;
                        tmo_q   <= '0;
                        ph_q    <= 2'd1;
                        state_q <= S_WAIT_H;
                    end
                end
                S_RB_R: begin
                    if (!busy) begin
                        rd_q     <= 1'b1;
                        tmo_q    <= '0;
                        ph_q     <= 2'd2;
                        rb_vld_q <= 1'b0;
                        state_q  <= S_WAIT_H;
                    end
                end
                S_RB_C: begin
                    if (!rb_vld_q || rb_q != ent_val) begin
                        if (!err_q) begin
                            err_idx_q <= idx_q;
                        end
                        err_q <= 1'b1;
                    end
                    state_q <= S_FETCH;
                    idx_q   <= idx_d;
                    ent_q   <= ent_d;
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign adr       = DEV_ADR;
    assign wr        = wr_q;
    assign wr_data   = wr_data_q;
    assign wr_bytes  = wr_bytes_q;
    assign init_busy = init_busy_q;
    assign init_done = init_done_q;
    assign err       = err_q;
    assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_cam_reg_init.sv
// Bench for cam_reg_init: scoreboard of expected register writes popped by a monitor, with a simple I2C master model.
module tb_cam_reg_init;
    localparam int BUSY_TO = 16;
`ifdef CAM_INIT_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int          EXP_RDS = RB ? 6 : 0;
    localparam logic [5:0]  EXP_IDX = RB ? 6'd3 : 6'd0;
    localparam logic [15:0] WR_TAB [8] = '{16'h1280, 16'h1204, 16'h40D0, 16'h1101,
                                           16'h0C04, 16'h3E19, 16'h7211, 16'h73F1};

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        start = 1'b0;
    logic        wr, rd, init_busy, init_done, err;
    logic        busy = 1'b0;
    logic        rd_data_en = 1'b0;
    logic [31:0] rd_data = '0;
    logic [6:0]  adr;
    logic [31:0] wr_data;
    logic [2:0]  wr_bytes, rd_bytes;
    logic [5:0]  err_idx;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    logic [15:0] exp_q[$];
    int          wr_log[$];
    bit          model_en = 1'b1;
    int          bcnt = 0;
    bit          rd_pend = 1'b0;
    logic [7:0]  cur = '0;
    logic [7:0]  rdv = '0;
    bit   [7:0]  mem [256];
    logic        wr_prev = 1'b0;

    cam_reg_init #(.DEV_ADR(7'h21), .CLK_HZ(100000), .PWRUP_MS(1), .BUSY_TO(BUSY_TO)) dut (
        .clk(clk), .rstb(rstb), .start(start), .wr(wr), .rd(rd), .adr(adr),
        .wr_data(wr_data), .wr_bytes(wr_bytes), .rd_bytes(rd_bytes), .rd_data(rd_data),
        .rd_data_en(rd_data_en), .busy(busy), .init_busy(init_busy), .init_done(init_done),
        .err(err), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // I2C master model: busy for 50 cycles per command, read data returned as busy falls.
    always @(negedge clk) begin
        rd_data_en = 1'b0;
        if (!rstb) begin
            bcnt    = 0;
            rd_pend = 1'b0;
        end else begin
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0 && rd_pend) begin
                    rd_data_en = 1'b1;
                    rd_data    = {rdv, 24'h0};
                    rd_pend    = 1'b0;
                end
            end
            if (model_en && (wr || rd)) begin
                bcnt = 50;
                if (wr) begin
                    cur = wr_data[31:24];
                    if (wr_bytes == 3'd2) mem[wr_data[31:24]] = wr_data[23:16];
                end
                if (rd) begin
                    rd_pend = 1'b1;
                    rdv     = (cur == 8'h40) ? 8'h00 : mem[cur];
                end
            end
        end
        busy = (bcnt != 0);
    end

    // Monitor: pops the scoreboard on every data write command.
    always @(negedge clk) begin
        if (rstb) begin
            if (wr) begin
                chk("wr pulse width", {31'b0, wr_prev}, 32'd0);
                if (wr_bytes == 3'd2) begin
                    wr_log.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected wr: got %0h expected none", wr_data);
                    end else begin
                        chk("wr_data", wr_data, {exp_q.pop_front(), 16'h0000});
                    end
                end else begin
                    chk("wr_bytes", {29'b0, wr_bytes}, RB ? 32'd1 : 32'd2);
                end
            end
            if (rd) begin
                rd_cnt++;
                chk("rd of reg 12", {31'b0, cur == 8'h12}, 32'd0);
                chk("rd_bytes", {29'b0, rd_bytes}, 32'd1);
            end
        end
        wr_prev = wr;
    end

    task automatic new_run();
        exp_q.delete();
        foreach (WR_TAB[i]) exp_q.push_back(WR_TAB[i]);
        wr_log.delete();
        rd_cnt = 0;
    endtask

    task automatic rst_checks(input string nm);
        chk({nm, " wr"}, {31'b0, wr}, 0);
        chk({nm, " rd"}, {31'b0, rd}, 0);
        chk({nm, " wr_data"}, wr_data, 0);
        chk({nm, " wr_bytes"}, {29'b0, wr_bytes}, 0);
        chk({nm, " rd_bytes"}, {29'b0, rd_bytes}, 0);
        chk({nm, " init_busy"}, {31'b0, init_busy}, 0);
        chk({nm, " init_done"}, {31'b0, init_done}, 0);
        chk({nm, " err"}, {31'b0, err}, 0);
        chk({nm, " err_idx"}, {26'b0, err_idx}, 0);
        chk({nm, " adr"}, {25'b0, adr}, 32'h21);
    endtask

    task automatic wait_wr(input int n, input int lim, input string nm);
        for (int i = 0; i < lim && wr_log.size() < n; i++) @(negedge clk);
        chk_rng(nm, wr_log.size(), n, 8);
    endtask

    task automatic wait_done(input int lim, input string nm);
        for (int i = 0; i < lim && init_done !== 1'b1; i++) @(negedge clk);
        chk({nm, " init_done"}, {31'b0, init_done}, 1);
    endtask

    task automatic end_checks(input string nm, input logic e_err, input logic [5:0] e_idx);
        chk({nm, " init_busy"}, {31'b0, init_busy}, 0);
        chk({nm, " err"}, {31'b0, err}, {31'b0, e_err});
        chk({nm, " err_idx"}, {26'b0, err_idx}, {26'b0, e_idx});
        chk({nm, " leftover expected"}, exp_q.size(), 0);
        chk({nm, " write count"}, wr_log.size(), 8);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int w;
        repeat (3) @(negedge clk);
        rst_checks("reset");

        // Run 1: power-up, full table, start during the 10 ms delay is ignored.
        new_run();
        rstb = 1'b1;
        repeat (50) @(negedge clk);
        chk("pwrup init_busy", {31'b0, init_busy}, 1);
        chk("pwrup init_done", {31'b0, init_done}, 0);
        wait_wr(1, 300, "run1 first wr seen");
        if (wr_log.size() > 0) chk_rng("first wr cycle", wr_log[0], 102, 104);
        repeat (200) @(negedge clk);
        pulse_start();
        chk("start in DLY init_busy", {31'b0, init_busy}, 1);
        wait_done(5000, "run1");
        if (wr_log.size() > 1) chk_rng("delay gap", wr_log[1] - wr_log[0], 1000, 1200);
        end_checks("run1", RB, EXP_IDX);
        chk("run1 rd count", rd_cnt, EXP_RDS);

        // Run 2: busy never rises, every command times out.
        model_en = 1'b0;
        new_run();
        pulse_start();
        chk("restart init_done", {31'b0, init_done}, 0);
        chk("restart err cleared", {31'b0, err}, 0);
        wait_wr(1, 300, "run2 first wr seen");
        if (wr_log.size() > 0) begin
            w = wr_log[0];
            for (int i = 0; i < 100 && cyc < w + BUSY_TO - 1; i++) @(negedge clk);
            chk("err before timeout", {31'b0, err}, 0);
            @(negedge clk);
            chk("err at timeout", {31'b0, err}, 1);
            chk("err_idx at timeout", {26'b0, err_idx}, 0);
        end
        wait_done(5000, "run2");
        end_checks("run2", 1'b1, 6'd0);

        // Run 3: start in DONE clears err; reset lands mid-WAIT_L at entry 4.
        model_en = 1'b1;
        new_run();
        pulse_start();
        chk("run3 err cleared", {31'b0, err}, 0);
        chk("run3 err_idx cleared", {26'b0, err_idx}, 0);
        chk("run3 init_busy", {31'b0, init_busy}, 1);
        wait_wr(4, 5000, "run3 entry 4 wr seen");
        repeat (20) @(negedge clk);
        chk("mid WAIT_L busy", {31'b0, busy}, 1);
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        rst_checks("mid reset");
        new_run();
        rstb = 1'b1;
        wait_wr(1, 300, "run4 first wr seen");
        if (wr_log.size() > 0) chk_rng("run4 first wr cycle", wr_log[0], 102, 104);
        wait_done(5000, "run4");
        end_checks("run4", RB, EXP_IDX);
        chk("run4 rd count", rd_cnt, EXP_RDS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
